tpumac_pipe: RTL and testbench
==============================

// Module: tpumac_pipe
// PURPOSE
//  Pipelined, parametrised successor to the single-cycle TPU MAC cell, used as the PE of the systolic array.
//  Multiply and accumulate are split into two stages so the cell closes timing at wider operands.
//  Accumulation is selectable between saturating and wrapping, with a sticky overflow flag.
//  A/B forwarding to neighbouring PEs keeps the same one-register latency as the previous cell.
// PARAMETERS
//  BITS_AB   8   signed width of A/B operands and of Aout/Bout
//  BITS_C    16  signed accumulator width; must be >= 2*BITS_AB (elaboration $error otherwise)
//  SATURATE  1   1: clamp sums to [-2^(BITS_C-1), 2^(BITS_C-1)-1]; 0: two's-complement wrap
// PORTS
//  clk    in   1        clock; all state updates on posedge
//  rst_n  in   1        synchronous active-low reset
//  en     in   1        pipeline advance; 0 = full stall
//  WrEn   in   1        load accumulator from Cin (independent of en)
//  Ain    in   BITS_AB  signed operand A
//  Bin    in   BITS_AB  signed operand B
//  Cin    in   BITS_C   signed accumulator preload value
//  Aout   out  BITS_AB  registered A, forwarded east
//  Bout   out  BITS_AB  registered B, forwarded south
//  Cout   out  BITS_C   accumulator register
//  pend   out  1        stage-1 product is valid and not yet accumulated
//  ovf    out  1        sticky overflow of any accumulate since last WrEn/reset
// BEHAVIOUR
//  Reset: on a posedge with rst_n=0, A, B, P, C <= 0 and pend, ovf <= 0. Reset overrides en and WrEn.
//  Stage 1 (en=1): A <= Ain, B <= Bin, P <= Ain*Bin (2*BITS_AB signed, full precision), pend <= 1.
//  Stage 2 (en=1, WrEn=0, pend=1): C <= acc(C + sext(P)).
//   Sum is computed at BITS_C+1 bits; overflow = sum outside the BITS_C signed range.
//   SATURATE=1: clamp to max/min. SATURATE=0: keep the low BITS_C bits.
//   On overflow in either mode, ovf <= 1.
//  Latency: operands sampled at enabled edge k are reflected in Cout after the next enabled edge k'.
//   With en held high, k' = k+1. Stage 1 and stage 2 update on the same edge (P is consumed and refilled).
//  Stall (en=0): A, B, P, pend, C and ovf all hold. An in-flight product is never lost or duplicated.
//  WrEn=1 (any en): C <= Cin and ovf <= 0.
//   If pend=1 and en=1 on that edge, the old product is discarded, not accumulated.
//   Stage 1 still captures Ain/Bin/product when en=1.
//   If en=0, pend and P hold, and the product accumulates into the new C on the next enabled edge.
//  The first enabled edge after reset accumulates nothing (pend=0); it only fills stage 1.
//  Outputs are plain register outputs; there is no combinational input-to-output path.
// TESTING (BITS_AB=8, BITS_C=16 unless noted)
//  1 Reset: drive random state, then rst_n=0 for 1 edge -> Aout=Bout=Cout=0, pend=0, ovf=0, even with en=WrEn=1.
//  2 Basic MAC: WrEn=1,Cin=100; then en=1,A=3,B=-4; then en=1,A=0,B=0 -> Cout=88, Aout=0, pend=1, ovf=0.
//  3 Stall: capture A=5,B=6 with en=1; hold en=0 for 3 cycles -> Cout, Aout=5, Bout=6, pend=1 unchanged;
//    then en=1 -> Cout += 30.
//  4 Saturation (SATURATE=1): Cin=32000 plus 127*127 -> Cout=32767, ovf=1;
//    Cin=-32000 plus -128*127 -> Cout=-32768, ovf=1; ovf stays 1 through later in-range accumulates.
//  5 Wrap (SATURATE=0): Cin=32000 plus 127*127 -> Cout=-17407, ovf=1.
//  6 WrEn vs pending: pend=1 with P=30, then en=1,WrEn=1,Cin=7 -> Cout=7, ovf=0, P=new product;
//    repeat with en=0 -> next enabled edge gives Cout=37.
//  7 Random: 1000 cycles of random en/WrEn/A/B/Cin checked against a cycle model; rst_n pulsed mid-run.

Source files
------------

// File: rtl/tpumac_if.sv
// tpumac_if: operand/result bundle for one tpumac_pipe processing element.
//   master: drives en, WrEn, Ain, Bin, Cin; observes Aout, Bout, Cout, pend, ovf
//   slave : the PE itself (inverse directions)
// Parameters must match the tpumac_pipe instance the interface is bound to.
interface tpumac_if #(
  parameter int BITS_AB = 8,
  parameter int BITS_C  = 16
);
  logic                      en;
  logic                      WrEn;
  logic signed [BITS_AB-1:0] Ain;
  logic signed [BITS_AB-1:0] Bin;
  logic signed [BITS_C-1:0]  Cin;
  logic signed [BITS_AB-1:0] Aout;
  logic signed [BITS_AB-1:0] Bout;
  logic signed [BITS_C-1:0]  Cout;
  logic                      pend;
  logic                      ovf;

  modport master (
    output en, WrEn, Ain, Bin, Cin,
    input  Aout, Bout, Cout, pend, ovf
  );

  modport slave (
    input  en, WrEn, Ain, Bin, Cin,
    output Aout, Bout, Cout, pend, ovf
  );
endinterface

// File: rtl/tpumac_pipe.sv
// tpumac_pipe: two-stage multiply-accumulate PE for the systolic array.
//   Stage 1 registers the operands (forwarded east/south) and their full
//   precision product; stage 2 folds the held product into the accumulator,
//   either saturating or wrapping, and records overflow in a sticky flag.
// Ports:
//   clk    clock, all state changes on posedge
//   rst_n  synchronous active-low reset, overrides en and WrEn
//   bus    tpumac_if slave: en (advance), WrEn (preload C from Cin),
//          Ain/Bin operands, Aout/Bout/Cout registered outputs,
//          pend (product waiting in stage 1), ovf (sticky overflow)
module tpumac_pipe #(
  parameter int BITS_AB  = 8,
  parameter int BITS_C   = 16,
  parameter int SATURATE = 1
) (
  input  logic     clk,
  input  logic     rst_n,
  tpumac_if.slave  bus
);
  localparam int PW = 2 * BITS_AB;

  if (BITS_C < PW) begin : g_width_check
    $error("tpumac_pipe: BITS_C (%0d) must be >= 2*BITS_AB (%0d)", BITS_C, PW);
  end

  localparam logic signed [BITS_C-1:0] C_MAX = {1'b0, {(BITS_C-1){1'b1}}};
  localparam logic signed [BITS_C-1:0] C_MIN = {1'b1, {(BITS_C-1){1'b0}}};

  logic signed [BITS_AB-1:0] a_q, b_q;
  logic signed [PW-1:0]      p_q;
  logic signed [BITS_C-1:0]  c_q;
  logic                      pend_q, ovf_q;

  logic signed [PW-1:0]      prod;
  logic signed [BITS_C:0]    sum;
  logic                      sum_ovf;
  logic signed [BITS_C-1:0]  acc_val;

  // NOTE: every signal written here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    prod    = '0;
    sum     = '0;
    sum_ovf = 1'b0;
    acc_val = '0;

    prod = bus.Ain * bus.Bin;

    // One guard bit above the accumulator: the sum can never overflow this
    // width, and the top two bits disagree exactly when the true sum is out
    // of the BITS_C signed range.
    sum     = {c_q[BITS_C-1], c_q} + {{(BITS_C+1-PW){p_q[PW-1]}}, p_q};
    sum_ovf = sum[BITS_C] ^ sum[BITS_C-1];
    acc_val = sum[BITS_C-1:0];
    if (sum_ovf && (SATURATE != 0)) begin
      // The guard bit carries the true sign: negative clamps to min.
      acc_val = sum[BITS_C] ? C_MIN : C_MAX;
    end
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples the pre-edge values; the accumulate below must see the old P
  // while stage 1 refills it on the same edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      p_q    <= '0;
      c_q    <= '0;
      pend_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      if (bus.en) begin
        a_q    <= bus.Ain;
        b_q    <= bus.Bin;
        p_q    <= prod;
        pend_q <= 1'b1;
      end
      // A preload wins over the pending product; with en=1 that product is
      // dropped (P refills above), with en=0 it stays queued for the new C.
      if (bus.WrEn) begin
        c_q   <= bus.Cin;
        ovf_q <= 1'b0;
      end else if (bus.en && pend_q) begin
        c_q <= acc_val;
        if (sum_ovf) begin
          ovf_q <= 1'b1;
        end
      end
    end
  end

  assign bus.Aout = a_q;
  assign bus.Bout = b_q;
  assign bus.Cout = c_q;
  assign bus.pend = pend_q;
  assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_tpumac_pipe.sv
// tb_tpumac_pipe: drives a saturating and a wrapping tpumac_pipe with the
// same stimulus and compares both against an integer-arithmetic model of
// the PE: "A/B/P update when enabled, C absorbs the previous product".
module tb_tpumac_pipe;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  tpumac_if #(.BITS_AB(8), .BITS_C(16)) ifs ();
  tpumac_if #(.BITS_AB(8), .BITS_C(16)) ifw ();

  tpumac_pipe #(.BITS_AB(8), .BITS_C(16), .SATURATE(1)) dut_s (
    .clk(clk), .rst_n(rst_n), .bus(ifs.slave)
  );
  tpumac_pipe #(.BITS_AB(8), .BITS_C(16), .SATURATE(0)) dut_w (
    .clk(clk), .rst_n(rst_n), .bus(ifw.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state, plain integers.
  int m_a, m_b, m_p, m_pend;
  int m_cs, m_os;  // saturating PE: accumulator, overflow flag
  int m_cw, m_ow;  // wrapping PE

  function automatic int clamp16(input int s);
    if (s > 32767)  return 32767;
    if (s < -32768) return -32768;
    return s;
  endfunction

  function automatic int wrap16(input int s);
    int t;
    t = s & 32'h0000FFFF;
    if (t > 32767) t = t - 65536;
    return t;
  endfunction

  // Apply one clock edge to both DUTs and advance the model; returns #1
  // after the edge so outputs are settled for comparison.
  task automatic tick(input logic r, input logic e, input logic w,
                      input int a, input int b, input int cin);
    int sum;
    rst_n    = r;
    ifs.en   = e;          ifw.en   = e;
    ifs.WrEn = w;          ifw.WrEn = w;
    ifs.Ain  = 8'(a);      ifw.Ain  = 8'(a);
    ifs.Bin  = 8'(b);      ifw.Bin  = 8'(b);
    ifs.Cin  = 16'(cin);   ifw.Cin  = 16'(cin);
    @(posedge clk);
    if (!r) begin
      m_a = 0; m_b = 0; m_p = 0; m_pend = 0;
      m_cs = 0; m_os = 0; m_cw = 0; m_ow = 0;
    end else begin
      if (w) begin
        m_cs = cin; m_cw = cin; m_os = 0; m_ow = 0;
      end else if (e && m_pend != 0) begin
        sum = m_cs + m_p;
        if (sum > 32767 || sum < -32768) m_os = 1;
        m_cs = clamp16(sum);
        sum = m_cw + m_p;
        if (sum > 32767 || sum < -32768) m_ow = 1;
        m_cw = wrap16(sum);
      end
      if (e) begin
        m_a = a; m_b = b; m_p = a * b; m_pend = 1;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 6; i++)
      tick(1'b1, 1'b1, ($urandom_range(0, 3) == 0), $signed(8'($urandom)),
           $signed(8'($urandom)), $signed(16'($urandom)));
    tick(1'b0, 1'b1, 1'b1, 55, -66, 1234);
    checks++; if (integer'(ifs.Aout) !== 0) begin errors++; $display("FAIL reset_aout got %0d exp 0", ifs.Aout); end
    checks++; if (integer'(ifs.Bout) !== 0) begin errors++; $display("FAIL reset_bout got %0d exp 0", ifs.Bout); end
    checks++; if (integer'(ifs.Cout) !== 0) begin errors++; $display("FAIL reset_cout got %0d exp 0", ifs.Cout); end
    checks++; if (integer'(ifw.Cout) !== 0) begin errors++; $display("FAIL reset_cout_w got %0d exp 0", ifw.Cout); end
    checks++; if (ifs.pend !== 1'b0) begin errors++; $display("FAIL reset_pend got %b exp 0", ifs.pend); end
    checks++; if (ifs.ovf !== 1'b0 || ifw.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b/%b exp 0/0", ifs.ovf, ifw.ovf); end
  endtask

  task automatic test_basic_mac();
    tick(1'b1, 1'b0, 1'b1, 0, 0, 100);
    tick(1'b1, 1'b1, 1'b0, 3, -4, 0);
    checks++; if (integer'(ifs.Cout) !== 100) begin errors++; $display("FAIL basic_first_edge got %0d exp 100", ifs.Cout); end
    tick(1'b1, 1'b1, 1'b0, 0, 0, 0);
    checks++; if (integer'(ifs.Cout) !== 88) begin errors++; $display("FAIL basic_cout got %0d exp 88", ifs.Cout); end
    checks++; if (integer'(ifw.Cout) !== 88) begin errors++; $display("FAIL basic_cout_w got %0d exp 88", ifw.Cout); end
    checks++; if (integer'(ifs.Aout) !== 0) begin errors++; $display("FAIL basic_aout got %0d exp 0", ifs.Aout); end
    checks++; if (ifs.pend !== 1'b1) begin errors++; $display("FAIL basic_pend got %b exp 1", ifs.pend); end
    checks++; if (ifs.ovf !== 1'b0) begin errors++; $display("FAIL basic_ovf got %b exp 0", ifs.ovf); end
  endtask

  task automatic test_stall();
    tick(1'b1, 1'b1, 1'b0, 5, 6, 0);
    for (int i = 0; i < 3; i++) begin
      tick(1'b1, 1'b0, 1'b0, $signed(8'($urandom)), $signed(8'($urandom)), 0);
      checks++;
      if (integer'(ifs.Cout) !== 88 || integer'(ifs.Aout) !== 5 ||
          integer'(ifs.Bout) !== 6 || ifs.pend !== 1'b1) begin
        errors++;
        $display("FAIL stall_hold cyc %0d got C=%0d A=%0d B=%0d pend=%b exp C=88 A=5 B=6 pend=1",
                 i, ifs.Cout, ifs.Aout, ifs.Bout, ifs.pend);
      end
    end
    tick(1'b1, 1'b1, 1'b0, 0, 0, 0);
    checks++; if (integer'(ifs.Cout) !== 118) begin errors++; $display("FAIL stall_resume got %0d exp 118", ifs.Cout); end
  endtask

  task automatic test_saturate_wrap();
    tick(1'b1, 1'b0, 1'b1, 0, 0, 32000);
    tick(1'b1, 1'b1, 1'b0, 127, 127, 0);
    tick(1'b1, 1'b1, 1'b0, -1, 1, 0);
    checks++; if (integer'(ifs.Cout) !== 32767) begin errors++; $display("FAIL sat_pos got %0d exp 32767", ifs.Cout); end
    checks++; if (ifs.ovf !== 1'b1) begin errors++; $display("FAIL sat_pos_ovf got %b exp 1", ifs.ovf); end
    checks++; if (integer'(ifw.Cout) !== -17407) begin errors++; $display("FAIL wrap_pos got %0d exp -17407", ifw.Cout); end
    checks++; if (ifw.ovf !== 1'b1) begin errors++; $display("FAIL wrap_pos_ovf got %b exp 1", ifw.ovf); end
    tick(1'b1, 1'b1, 1'b0, 0, 0, 0);
    checks++;
    if (integer'(ifs.Cout) !== 32766 || ifs.ovf !== 1'b1) begin
      errors++; $display("FAIL sat_sticky got C=%0d ovf=%b exp C=32766 ovf=1", ifs.Cout, ifs.ovf);
    end
    tick(1'b1, 1'b1, 1'b1, -128, 127, -32000);
    checks++;
    if (integer'(ifs.Cout) !== -32000 || ifs.ovf !== 1'b0 || ifw.ovf !== 1'b0) begin
      errors++; $display("FAIL wren_clears got C=%0d ovf=%b/%b exp C=-32000 ovf=0/0", ifs.Cout, ifs.ovf, ifw.ovf);
    end
    tick(1'b1, 1'b1, 1'b0, 0, 0, 0);
    checks++;
    if (integer'(ifs.Cout) !== -32768 || ifs.ovf !== 1'b1) begin
      errors++; $display("FAIL sat_neg got C=%0d ovf=%b exp C=-32768 ovf=1", ifs.Cout, ifs.ovf);
    end
    checks++;
    if (integer'(ifw.Cout) !== 17280 || ifw.ovf !== 1'b1) begin
      errors++; $display("FAIL wrap_neg got C=%0d ovf=%b exp C=17280 ovf=1", ifw.Cout, ifw.ovf);
    end
  endtask

  task automatic test_wren_vs_pending();
    tick(1'b1, 1'b1, 1'b0, 5, 6, 0);
    tick(1'b1, 1'b1, 1'b1, 2, 3, 7);
    checks++;
    if (integer'(ifs.Cout) !== 7 || ifs.ovf !== 1'b0) begin
      errors++; $display("FAIL wren_discard got C=%0d ovf=%b exp C=7 ovf=0", ifs.Cout, ifs.ovf);
    end
    tick(1'b1, 1'b1, 1'b0, 0, 0, 0);
    checks++; if (integer'(ifs.Cout) !== 13) begin errors++; $display("FAIL wren_new_product got %0d exp 13", ifs.Cout); end
    tick(1'b1, 1'b1, 1'b0, 5, 6, 0);
    tick(1'b1, 1'b0, 1'b1, 9, 9, 7);
    checks++;
    if (integer'(ifs.Cout) !== 7 || ifs.pend !== 1'b1) begin
      errors++; $display("FAIL wren_stalled got C=%0d pend=%b exp C=7 pend=1", ifs.Cout, ifs.pend);
    end
    tick(1'b1, 1'b1, 1'b0, 0, 0, 0);
    checks++; if (integer'(ifs.Cout) !== 37) begin errors++; $display("FAIL wren_kept_product got %0d exp 37", ifs.Cout); end
  endtask

  task automatic test_random();
    int a, b, cin;
    logic r, e, w;
    for (int i = 0; i < 1000; i++) begin
      a   = $signed(8'($urandom));
      b   = $signed(8'($urandom));
      cin = $signed(16'($urandom));
      r   = !(i == 500 || i == 501);
      e   = ($urandom_range(0, 3) != 0);
      w   = ($urandom_range(0, 9) == 0);
      tick(r, e, w, a, b, cin);
      checks++;
      if (integer'(ifs.Aout) !== m_a || integer'(ifs.Bout) !== m_b ||
          ifs.pend !== 1'(m_pend) || integer'(ifw.Aout) !== m_a) begin
        errors++;
        $display("FAIL rand_stage1 cyc %0d got A=%0d B=%0d pend=%b exp A=%0d B=%0d pend=%0d",
                 i, ifs.Aout, ifs.Bout, ifs.pend, m_a, m_b, m_pend);
      end
      checks++;
      if (integer'(ifs.Cout) !== m_cs || ifs.ovf !== 1'(m_os)) begin
        errors++;
        $display("FAIL rand_sat cyc %0d got C=%0d ovf=%b exp C=%0d ovf=%0d", i, ifs.Cout, ifs.ovf, m_cs, m_os);
      end
      checks++;
      if (integer'(ifw.Cout) !== m_cw || ifw.ovf !== 1'(m_ow)) begin
        errors++;
        $display("FAIL rand_wrap cyc %0d got C=%0d ovf=%b exp C=%0d ovf=%0d", i, ifw.Cout, ifw.ovf, m_cw, m_ow);
      end
    end
  endtask

  initial begin
    tick(1'b0, 1'b0, 1'b0, 0, 0, 0);
    test_reset();
    test_basic_mac();
    test_stall();
    test_saturate_wrap();
    test_wren_vs_pending();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
